// File: rtl/pair_mul_seq.sv
// pair_mul_seq: emits selected pairwise products of three operands through one shared multiplier
module pair_mul_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in1,
  input  logic [W-1:0]   in2,
  input  logic [W-1:0]   in3,
  input  logic [2:0]     in_mask,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out1,
  output logic [1:0]     out_tag,
  output logic           out_last
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nxt;
  logic [W-1:0]   a1, a2, a3, op_a, op_b;
  logic [2:0]     rem, rem_rest;
  logic [2*W-1:0] prod;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // handshakes and next state; rem holds products not yet accepted, lowest set bit is the current beat
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == EMIT;
    rem_rest  = rem & (rem - 3'd1);
    out_last  = out_valid && rem_rest == 3'd0;
    state_nxt = state;
    if (in_valid && in_ready) state_nxt = EMIT;
    if (out_valid && out_ready && out_last) state_nxt = IDLE;
  end
  // current beat: tag from lowest pending bit, operands muxed into the single multiplier
  always_comb begin
    out_tag = rem[0] ? 2'd1 : rem[1] ? 2'd2 : rem[2] ? 2'd3 : 2'd0;
    op_a    = out_tag == 2'd1 ? a2 : a1;
    op_b    = out_tag == 2'd3 ? a2 : a3;
    prod    = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    out1    = out_tag == 2'd0 ? '0 : prod;
  end
  // operand capture on input handshake, retire one product per accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      a1  <= '0;
      a2  <= '0;
      a3  <= '0;
      rem <= '0;
    end else if (in_valid && in_ready) begin
      a1  <= in1;
      a2  <= in2;
      a3  <= in3;
      rem <= in_mask;
    end else if (out_valid && out_ready) begin
      rem <= rem_rest;
    end
  end
endmodule

// File: tb/tb_pair_mul_seq.sv
// tb_pair_mul_seq: scoreboard bench for pair_mul_seq
module tb_pair_mul_seq;
  localparam int W = 16;
  typedef struct packed {
    logic [1:0]     tag;
    logic [2*W-1:0] data;
    logic           last;
  } beat_t;
  logic           clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_last;
  logic [W-1:0]   in1 = 0, in2 = 0, in3 = 0;
  logic [2:0]     in_mask = 0;
  logic [2*W-1:0] out1;
  logic [1:0]     out_tag;
  beat_t          exp_q[$];
  beat_t          held, e;
  logic           prev_stall = 0;
  int             n_chk = 0, n_err = 0;

  pair_mul_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .in3(in3), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out_tag(out_tag), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  // monitor: compare accepted beats to the scoreboard, hold stability while stalled, in_ready vs busy
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      check("ready_vs_valid", in_ready, !out_valid);
      if (prev_stall) begin
        check("stall_data", out1, held.data);
        check("stall_tag", out_tag, held.tag);
        check("stall_last", out_last, held.last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat_tag", out_tag, e.tag);
          check("beat_data", out1, e.data);
          check("beat_last", out_last, e.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      held = '{out_tag, out1, out_last};
    end
  end

  task automatic push_exp(input logic [W-1:0] a, b, c, input logic [2:0] m);
    logic [2*W-1:0] p[3];
    p[0] = (2*W)'(b) * (2*W)'(c);
    p[1] = (2*W)'(a) * (2*W)'(c);
    p[2] = (2*W)'(a) * (2*W)'(b);
    if (m == 3'b000) exp_q.push_back('{2'd0, '0, 1'b1});
    for (int i = 0; i < 3; i++)
      if (m[i]) exp_q.push_back('{2'(i + 1), p[i], (m >> (i + 1)) == 3'b000});
  endtask

  // drive one operand set; returns one cycle after the handshake edge
  task automatic send(input logic [W-1:0] a, b, c, input logic [2:0] m);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) check("in_ready_timeout", 0, 1);
    in_valid = 1; in1 = a; in2 = b; in3 = c; in_mask = m;
    push_exp(a, b, c, m);
    @(posedge clk); #1;
    in_valid = 0;
    in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom); in_mask = 3'($urandom);
    check("first_beat_latency", out_valid, 1);
  endtask

  // wait for return to IDLE, optionally toggling out_ready each cycle; returns cycle count
  task automatic drain(input bit toggle, output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      if (toggle) out_ready = ~out_ready;
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 200) check("drain_timeout", 0, 1);
    out_ready = 1;
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out1", out1, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_last", out_last, 0);
    // three products, full throughput, k+1 cycles
    send(3, 5, 7, 3'b111);
    drain(0, cyc);
    check("k3_cycles", cyc, 3);
    // skip disabled product, full-width product
    send(16'hFFFF, 16'hFFFF, 2, 3'b101);
    drain(0, cyc);
    check("k2_cycles", cyc, 2);
    // empty mask gives one null beat
    send(9, 9, 9, 3'b000);
    check("null_tag", out_tag, 0);
    check("null_data", out1, 0);
    check("null_last", out_last, 1);
    drain(0, cyc);
    check("null_cycles", cyc, 1);
    // stalls every other cycle
    out_ready = 0;
    send(3, 5, 7, 3'b111);
    drain(1, cyc);
    // reset while second beat stalled
    out_ready = 1;
    send(3, 5, 7, 3'b111);
    @(posedge clk); #1;
    out_ready = 0;
    @(posedge clk); #1;
    check("stalled_beat_tag", out_tag, 2);
    rst = 1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    send(4, 100, 6, 3'b010);
    drain(0, cyc);
    check("k1_cycles", cyc, 1);
    // reset coinciding with a handshake discards the set
    in_valid = 1; in1 = 1; in2 = 2; in3 = 3; in_mask = 3'b111; rst = 1;
    @(posedge clk); #1;
    in_valid = 0; rst = 0;
    check("rst_hs_out_valid", out_valid, 0);
    check("rst_hs_in_ready", in_ready, 1);
    // random sets with random backpressure
    for (int i = 0; i < 30; i++) begin
      send(W'($urandom), W'($urandom), W'($urandom), 3'($urandom));
      drain($urandom_range(0, 1) == 1, cyc);
    end
    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pair_mul_seq.md
PAIR_MUL_SEQ -- requirements
Module: pair_mul_seq

Interface
REQ-001 Parameter: W, 16, operand width; product width is 2*W.
REQ-002 Clock/reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand set valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 in1, in2, in3  input  W each  operands.
REQ-008 in_mask  input  3  product select; bit0 = in2*in3 (tag 1), bit1 = in1*in3 (tag 2), bit2 = in1*in2 (tag 3).
REQ-009 out_valid  output  1  result beat valid.
REQ-010 out_ready  input  1  downstream accepts beat.
REQ-011 out1  output  2*W  result beat data.
REQ-012 out_tag  output  2  product code of the beat (0 = null beat, 1..3 as REQ-008).
REQ-013 out_last  output  1  final beat of the current operand set.

Function
REQ-014 A single shared unsigned W x W multiplier SHALL serve all products; no more than one multiply SHALL be issued per cycle.
REQ-015 States: IDLE, EMIT; in_ready SHALL equal (state == IDLE).
REQ-016 Input handshake = in_valid && in_ready; on it, in1..in3 and in_mask SHALL be registered and state SHALL go to EMIT.
REQ-017 Latency: first beat SHALL have out_valid = 1 in the cycle after the input handshake.
REQ-018 Beat order: enabled products emitted in ascending tag order (1, 2, 3); disabled products skipped with no gap cycle.
REQ-019 in_mask == 0: exactly one beat, out_tag = 0, out1 = 0, out_last = 1.
REQ-020 Products: unsigned, full 2*W bits, no truncation or saturation (0xFFFF*0xFFFF = 0xFFFE0001 for W=16).
REQ-021 Beat accepted when out_valid && out_ready; while out_valid && !out_ready, out1, out_tag, out_last SHALL hold stable.
REQ-022 After a non-last beat is accepted at cycle t, the next beat SHALL be valid at t+1 (full throughput under continuous out_ready).
REQ-023 out_last SHALL be 1 only on the final enabled beat; when it is accepted, state SHALL return to IDLE, with out_valid = 0 and in_ready = 1 in the next cycle.
REQ-024 Input changes on in1..in3/in_mask while in EMIT SHALL not affect beats in progress.
REQ-025 An operand set of k enabled products (k >= 1) SHALL occupy exactly k+1 cycles from input handshake to IDLE under continuous out_ready.

Reset
REQ-026 rst SHALL take effect at the next rising edge, overriding all other inputs.
REQ-027 Reset values: state IDLE, in_ready = 1 after reset released, out_valid = 0, out1 = 0, out_tag = 0, out_last = 0, operand and mask registers 0.
REQ-028 rst asserted mid-EMIT SHALL discard all remaining beats; no beat from the aborted set SHALL appear after reset.
REQ-029 rst asserted in the same cycle as an input handshake SHALL discard that set.

Verification
REQ-030 in1=3, in2=5, in3=7, mask=111, out_ready=1 -> beats (tag1, 35), (tag2, 21), (tag3, 15, last) on 3 consecutive cycles starting 1 cycle after handshake; in_ready high the cycle after.
REQ-031 mask=101, in1=0xFFFF, in2=0xFFFF, in3=2 -> beats (tag1, 0x1FFFE), (tag3, 0xFFFE0001, last); no tag-2 beat, no gap cycle.
REQ-032 mask=000 -> single beat tag 0, out1 = 0, out_last = 1; then IDLE.
REQ-033 mask=111, out_ready toggled 0/1 every cycle -> each beat held stable while stalled, order and values as REQ-030, in_ready stays 0 until last beat accepted.
REQ-034 rst asserted while second beat stalled -> next cycle out_valid = 0, in_ready = 1; new set mask=010 then yields only (tag2, in1*in3, last).
